ram_dp_param: RTL and testbench

RAM_DP_PARAM -- requirements
Module: ram_dp_param

---
 rtl/ram_dp_param.sv | 68 ++++++
 tb/tb_ram_dp_param.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param: byte-enabled dual-port RAM with async or registered read and a sequential clear FSM.
module ram_dp_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int READ_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_busy;
  assign w_busy = r_state == CLEAR;
  assign busy   = w_busy;
  // clr_ptr wraps to 0 naturally on the last clear edge, ready for the next clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else if (w_busy) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
      if (&r_clr_ptr) r_state <= IDLE;
    end else if (clr_req) begin
      r_state <= CLEAR;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_busy) r_mem[r_clr_ptr] <= '0;
    else if (!rst && we)
      for (int k = 0; k < NB; k++)
        if (wr_be[k]) r_mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
  end
  generate
    if (READ_MODE == 0) begin : g_async
      assign rd_data  = w_busy ? '0 : r_mem[rd_addr];
      assign rd_valid = rd_en & ~w_busy;
    end else begin : g_sync
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;
      // read-first: the memory array is sampled before this edge's write lands
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= rd_en & ~w_busy;
          if (rd_en & ~w_busy) r_rd_data <= r_mem[rd_addr];
        end
      end
      assign rd_data  = w_busy ? '0 : r_rd_data;
      assign rd_valid = r_rd_valid & ~w_busy;
    end
  endgenerate
endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: checks async 8-bit, registered 8-bit and async 32-bit RAMs against a behavioural model.
module tb_ram_dp_param;
  logic        clk = 0, rst = 0, clr_req = 0, we = 0, rd_en = 0;
  logic [3:0]  wr_addr = 0, rd_addr = 0, wr_be = 0;
  logic [31:0] wr_data = 0;
  logic [7:0]  d0, d1;
  logic [31:0] d2;
  logic        v0, v1, v2, b0, b1, b2;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;

  ram_dp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(0)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0), .busy(b0));
  ram_dp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1), .busy(b1));
  ram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(0)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2), .busy(b2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a clear is a countdown of remaining edges; the memory becomes zero when it finishes
  logic [7:0]  m8 [16];
  logic [31:0] m32 [16];
  logic [7:0]  md1 = 0;
  logic        mv1 = 0, started = 0;
  int          rem = 16;
  always @(posedge clk) begin
    if (rst) begin
      rem = 16; md1 = 0; mv1 = 0; started = 1;
    end else if (rem > 0) begin
      mv1 = 0;
      rem--;
      if (rem == 0) for (int i = 0; i < 16; i++) begin m8[i] = 0; m32[i] = 0; end
    end else begin
      mv1 = rd_en;
      if (rd_en) md1 = m8[rd_addr];
      if (we) begin
        if (wr_be[0]) m8[wr_addr] = wr_data[7:0];
        for (int k = 0; k < 4; k++) if (wr_be[k]) m32[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
      end
      if (clr_req) rem = 16;
    end
  end

  always @(negedge clk) if (started) begin
    chk("busy0", b0, rem > 0);
    chk("busy1", b1, rem > 0);
    chk("busy2", b2, rem > 0);
    chk("valid0", v0, rd_en && rem == 0);
    chk("valid1", v1, mv1 && rem == 0);
    chk("valid2", v2, rd_en && rem == 0);
    chk("data0", d0, rem > 0 ? 8'h0 : m8[rd_addr]);
    chk("data1", d1, rem > 0 ? 8'h0 : md1);
    chk("data2", d2, rem > 0 ? 32'h0 : m32[rd_addr]);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (b0 && n < 100) begin step(); n++; end
  endtask

  logic [31:0] st [16];
  int n;
  initial begin
    #200000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step();
    rst = 1; step(); step(); rst = 0;
    wait_idle(n);
    chk("rst_busy_len", n, 16);
    rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i; #1;
      chk("rst_zero0", d0, 0);
      chk("rst_zero2", d2, 0);
      step();
    end
    rd_en = 0;
    for (int i = 0; i < 16; i++) begin
      we = 1; wr_be = 4'hf; wr_addr = i; st[i] = $urandom; wr_data = st[i]; step();
    end
    we = 0; rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i; #1;
      chk("sweep0", d0, {24'h0, st[i][7:0]});
      chk("sweep2", d2, st[i]);
      step();
      chk("sweep1", d1, {24'h0, st[i][7:0]});
      chk("sweep1_valid", v1, 1);
    end
    rd_en = 0;
    we = 1; wr_addr = 3; wr_be = 4'hf; wr_data = 32'hAABBCCDD; step();
    wr_be = 4'b0101; wr_data = 32'h11223344; step();
    wr_be = 4'b0000; wr_data = 32'h0; step();
    we = 0; rd_addr = 3; #1;
    chk("be32", d2, 32'hAA22CC44);
    chk("be8", d0, 32'h44);
    we = 1; wr_addr = 5; wr_be = 4'hf; wr_data = 32'h5A; step();
    wr_data = 32'hA5; rd_en = 1; rd_addr = 5; step();
    we = 0;
    chk("rdw_old", d1, 8'h5A);
    step();
    chk("rdw_new", d1, 8'hA5);
    rd_en = 0;
    clr_req = 1; step(); clr_req = 0;
    we = 1; wr_addr = 2; wr_data = 32'hFF; wr_be = 4'hf; rd_en = 1; rd_addr = 2;
    n = 0;
    while (b0 && n < 100) begin
      chk("blk_valid0", v0, 0);
      chk("blk_valid1", v1, 0);
      clr_req = (n == 4);
      step(); n++;
      we = 0; clr_req = 0;
    end
    chk("clr_busy_len", n, 16);
    #1;
    chk("blk_addr2_0", d0, 0);
    chk("blk_addr2_2", d2, 0);
    step();
    chk("blk_addr2_1", d1, 0);
    rd_en = 0;
    clr_req = 1; step(); clr_req = 0;
    repeat (8) step();
    rst = 1; step(); step(); rst = 0;
    wait_idle(n);
    chk("midclr_busy_len", n, 16);
    rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = i; #1;
      chk("midclr_zero", d2, 0);
      step();
    end
    rd_en = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
